// File: rtl/adc_evt_readout_ctrl_if.sv
// adc_evt_readout_ctrl_if: paired Avalon-ST style write ports toward the two event FIFOs
interface adc_evt_readout_ctrl_if;
   logic [31:0] fifo0_writedata;
   logic        fifo0_write;
   logic        fifo0_waitrequest;
   logic [31:0] fifo1_writedata;
   logic        fifo1_write;
   logic        fifo1_waitrequest;
   modport master (
      output fifo0_writedata, fifo0_write, fifo1_writedata, fifo1_write,
      input  fifo0_waitrequest, fifo1_waitrequest
   );
   modport slave (
      input  fifo0_writedata, fifo0_write, fifo1_writedata, fifo1_write,
      output fifo0_waitrequest, fifo1_waitrequest
   );
endinterface

// File: rtl/adc_evt_readout_ctrl.sv
// adc_evt_readout_ctrl: trigger-driven framing of two ADC channels into header/data/trailer
// FIFO word streams, with a small per-channel buffer absorbing FIFO backpressure.
module adc_evt_readout_ctrl #(
   parameter int ADC_W     = 14,
   parameter int NWORDS    = 64,
   parameter int BUF_DEPTH = 4,
   parameter int HOLDOFF   = 16
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic [ADC_W-1:0]    bs1_data,
   input  logic [ADC_W-1:0]    bs2_data,
   input  logic                trig_in,
   input  logic                write_en,
   input  logic [1:0]          trig_mode,
   input  logic [ADC_W-1:0]    threshold,
   adc_evt_readout_ctrl_if.master fifo,
   output logic                busy,
   output logic [15:0]         evt_count,
   output logic [15:0]         drop_count
);
   localparam int AW  = $clog2(BUF_DEPTH);
   localparam int CW  = $clog2(BUF_DEPTH + 1);
   localparam int HCW = $clog2(HOLDOFF + 1);
   typedef enum logic [2:0] {IDLE, HEADER, CAPTURE, TRAILER, HOLD} state_t;
   state_t                  state;
   logic [1:0][ADC_W-1:0]   cur, prv, hold;
   logic                    trig_r, trig_p, ext, trig, phase;
   logic [11:0]             wcnt;
   logic [HCW-1:0]          hcnt;
   logic [15:0]             evt_id;
   logic [1:0][7:0]         drops;
   logic [1:0]              tdone, hit, empty, full, pop, req, push, drop, wait_req;
   logic [1:0][31:0]        push_word;
   logic [31:0]             mem [2][BUF_DEPTH];
   logic [1:0][AW-1:0]      wp, rp;
   logic [1:0][CW-1:0]      cnt;
   logic [16:0]             drop_sum;
   always_ff @(posedge clk_clk or posedge reset_reset)
      if (reset_reset) begin
         cur    <= '0;
         prv    <= '0;
         trig_r <= 1'b0;
         trig_p <= 1'b0;
      end else begin
         cur    <= {bs2_data, bs1_data};
         prv    <= cur;
         trig_r <= trig_in;
         trig_p <= trig_r;
      end
   assign wait_req = {fifo.fifo1_waitrequest, fifo.fifo0_waitrequest};
   assign ext      = trig_r && !trig_p;
   assign trig     = trig_mode == 2'd0 ? ext :
                     trig_mode == 2'd1 ? hit[0] :
                     trig_mode == 2'd2 ? |hit : ext || |hit;
   // A full buffer still takes a push when its head leaves in the same cycle.
   always_comb begin
      hit       = '0;
      empty     = '0;
      full      = '0;
      pop       = '0;
      req       = '0;
      push      = '0;
      drop      = '0;
      push_word = '0;
      for (int c = 0; c < 2; c++) begin
         hit[c]       = prv[c] < threshold && cur[c] >= threshold;
         empty[c]     = cnt[c] == '0;
         full[c]      = cnt[c] == CW'(BUF_DEPTH);
         pop[c]       = !empty[c] && !wait_req[c];
         req[c]       = state == HEADER || (state == CAPTURE && phase) || (state == TRAILER && !tdone[c]);
         push[c]      = req[c] && (!full[c] || pop[c]);
         drop[c]      = state == CAPTURE && phase && !push[c];
         push_word[c] = state == HEADER  ? {4'hA, 3'b0, 1'(c), 8'h00, evt_count} :
                        state == TRAILER ? {4'hE, 3'b0, 1'(c), drops[c], evt_id} :
                        (32'(hold[c]) << 16) | 32'(cur[c]);
      end
   end
   assign drop_sum = {1'b0, drop_count} + 17'(drop[0]) + 17'(drop[1]);
   always_ff @(posedge clk_clk or posedge reset_reset)
      if (reset_reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
         for (int c = 0; c < 2; c++)
            for (int i = 0; i < BUF_DEPTH; i++)
               mem[c][i] <= '0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (push[c]) begin
               mem[c][wp[c]] <= push_word[c];
               wp[c]         <= wp[c] + AW'(1);
            end
            if (pop[c])
               rp[c] <= rp[c] + AW'(1);
            cnt[c] <= cnt[c] + CW'(push[c]) - CW'(pop[c]);
         end
      end
   assign fifo.fifo0_write     = !empty[0];
   assign fifo.fifo1_write     = !empty[1];
   assign fifo.fifo0_writedata = mem[0][rp[0]];
   assign fifo.fifo1_writedata = mem[1][rp[1]];
   always_ff @(posedge clk_clk or posedge reset_reset)
      if (reset_reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         evt_count  <= '0;
         drop_count <= '0;
         evt_id     <= '0;
         hold       <= '0;
         phase      <= 1'b0;
         wcnt       <= '0;
         hcnt       <= '0;
         tdone      <= '0;
         drops      <= '0;
      end else begin
         drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         for (int c = 0; c < 2; c++)
            if (drop[c] && drops[c] != 8'hFF)
               drops[c] <= drops[c] + 8'd1;
         case (state)
            IDLE:
               if (trig && write_en && empty[0] && empty[1]) begin
                  state <= HEADER;
                  busy  <= 1'b1;
               end
            HEADER: begin
               evt_count <= evt_count + 16'd1;
               evt_id    <= evt_count;
               hold      <= cur;
               phase     <= 1'b1;
               wcnt      <= '0;
               drops     <= '0;
               tdone     <= '0;
               state     <= CAPTURE;
            end
            CAPTURE:
               if (!phase) begin
                  hold  <= cur;
                  phase <= 1'b1;
               end else begin
                  phase <= 1'b0;
                  wcnt  <= wcnt + 12'd1;
                  if (wcnt == 12'(NWORDS - 1))
                     state <= TRAILER;
               end
            TRAILER: begin
               tdone <= tdone | push;
               if (&(tdone | push)) begin
                  hcnt  <= '0;
                  state <= HOLD;
               end
            end
            HOLD: begin
               hcnt <= hcnt + HCW'(1);
               if (hcnt == HCW'(HOLDOFF - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
endmodule

// File: tb/tb_adc_evt_readout_ctrl.sv
// tb_adc_evt_readout_ctrl: directed event scenarios; expected FIFO words are queued per
// channel at trigger time and a monitor compares every accepted FIFO write against them.
module tb_adc_evt_readout_ctrl;
   localparam int N = 8;
   logic        clk_clk = 1'b0, reset_reset = 1'b1;
   logic [13:0] bs1_data = '0, bs2_data = '0, threshold = '0;
   logic        trig_in = 1'b0, write_en = 1'b0, ramp = 1'b0, rnd = 1'b0;
   logic [1:0]  trig_mode = '0;
   logic        busy;
   logic [15:0] evt_count, drop_count;
   int          n_chk = 0, n_fail = 0;
   logic [31:0] q0[$], q1[$];
   logic [1:0]  pstall = '0;
   logic [31:0] pdata [2];
   adc_evt_readout_ctrl_if fif();
   adc_evt_readout_ctrl #(.ADC_W(14), .NWORDS(N), .BUF_DEPTH(4), .HOLDOFF(16)) dut (
      .clk_clk(clk_clk), .reset_reset(reset_reset), .bs1_data(bs1_data), .bs2_data(bs2_data),
      .trig_in(trig_in), .write_en(write_en), .trig_mode(trig_mode), .threshold(threshold),
      .fifo(fif.master), .busy(busy), .evt_count(evt_count), .drop_count(drop_count)
   );
   always #5 clk_clk = ~clk_clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [31:0] dw(input logic [13:0] a, input logic [13:0] b);
      return {2'b0, a, 2'b0, b};
   endfunction
   task automatic exp_event(input logic [15:0] evt, input logic [13:0] s1, input logic [13:0] s2,
                            input int inc, input int keep0, input logic [7:0] d0);
      q0.push_back({4'hA, 4'h0, 8'h00, evt});
      q1.push_back({4'hA, 4'h1, 8'h00, evt});
      for (int i = 0; i < N; i++) begin
         if (i < keep0) q0.push_back(dw(14'(s1 + 2*i*inc), 14'(s1 + (2*i+1)*inc)));
         q1.push_back(dw(14'(s2 + 2*i*inc), 14'(s2 + (2*i+1)*inc)));
      end
      q0.push_back({4'hE, 4'h0, d0, evt});
      q1.push_back({4'hE, 4'h1, 8'h00, evt});
   endtask
   task automatic mon_ch(input int ch, input logic wr, input logic wt, input logic [31:0] d);
      logic [31:0] e;
      if (pstall[ch]) begin
         check($sformatf("stall%0d_write", ch), 32'(wr), 32'd1);
         check($sformatf("stall%0d_data", ch), d, pdata[ch]);
      end
      if (wr && !wt) begin
         if ((ch == 0 ? q0.size() : q1.size()) == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_word%0d: got %h expected none", ch, d);
         end else begin
            if (ch == 0) e = q0.pop_front();
            else e = q1.pop_front();
            check($sformatf("word%0d", ch), d, e);
         end
      end
      pstall[ch] = wr && wt;
      pdata[ch]  = d;
   endtask
   initial forever begin
      @(negedge clk_clk);
      #1;
      if (reset_reset) pstall = '0;
      else begin
         mon_ch(0, fif.fifo0_write, fif.fifo0_waitrequest, fif.fifo0_writedata);
         mon_ch(1, fif.fifo1_write, fif.fifo1_waitrequest, fif.fifo1_writedata);
      end
   end
   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clk_clk);
         if (ramp) begin
            bs1_data = bs1_data + 14'd1;
            bs2_data = bs2_data + 14'd1;
         end
         if (rnd) begin
            fif.fifo0_waitrequest = 1'($urandom_range(0, 1)) & ~fif.fifo0_waitrequest;
            fif.fifo1_waitrequest = 1'($urandom_range(0, 1)) & ~fif.fifo1_waitrequest;
         end
      end
   endtask
   task automatic wait_idle(input string name);
      int k = 0;
      step(3);
      while ((busy || q0.size() != 0 || q1.size() != 0) && k < 300) begin
         step();
         k++;
      end
      check({name, "_busy"}, 32'(busy), 32'd0);
      check({name, "_left0"}, 32'(q0.size()), 32'd0);
      check({name, "_left1"}, 32'(q1.size()), 32'd0);
   endtask
   initial begin
      fif.fifo0_waitrequest = 1'b0;
      fif.fifo1_waitrequest = 1'b0;
      #1;
      check("rst_write0", 32'(fif.fifo0_write), 32'd0);
      check("rst_write1", 32'(fif.fifo1_write), 32'd0);
      check("rst_data0", fif.fifo0_writedata, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_evt", 32'(evt_count), 32'd0);
      check("rst_drop", 32'(drop_count), 32'd0);
      step(2);
      reset_reset = 1'b0;
      write_en = 1'b1;
      step(3);
      // external trigger, ramp data, first packed samples are 0 and 1
      ramp = 1'b1;
      bs1_data = 14'h3FFF;
      bs2_data = 14'h1000;
      trig_in = 1'b1;
      exp_event(16'd0, 14'h0000, 14'h1001, 1, N, 8'h00);
      step(3);
      trig_in = 1'b0;
      wait_idle("ext");
      check("ext_evt", 32'(evt_count), 32'd1);
      check("ext_drop", 32'(drop_count), 32'd0);
      // threshold crossing on bs1; external pulses in CAPTURE and HOLDOFF must be ignored
      ramp = 1'b0;
      trig_mode = 2'd3;
      threshold = 14'h100;
      bs1_data = 14'h0FF;
      bs2_data = 14'h050;
      step(4);
      bs1_data = 14'h100;
      exp_event(16'd1, 14'h100, 14'h050, 0, N, 8'h00);
      step(6);
      trig_in = 1'b1;
      step(2);
      trig_in = 1'b0;
      step(17);
      trig_in = 1'b1;
      step(2);
      trig_in = 1'b0;
      wait_idle("thr");
      step(10);
      check("thr_evt", 32'(evt_count), 32'd2);
      // FIFO 0 stalled through CAPTURE: three data words fit behind the header
      trig_mode = 2'd0;
      ramp = 1'b1;
      bs1_data = 14'h0FFF;
      bs2_data = 14'h0200;
      fif.fifo0_waitrequest = 1'b1;
      trig_in = 1'b1;
      exp_event(16'd2, 14'h1000, 14'h0201, 1, 3, 8'h05);
      step();
      trig_in = 1'b0;
      step(19);
      fif.fifo0_waitrequest = 1'b0;
      wait_idle("stall");
      check("stall_drop", 32'(drop_count), 32'd5);
      check("stall_evt", 32'(evt_count), 32'd3);
      // pseudo-random waitrequest on both channels, never stalled two cycles in a row
      bs1_data = 14'h1233;
      bs2_data = 14'h3000;
      rnd = 1'b1;
      trig_in = 1'b1;
      exp_event(16'd3, 14'h1234, 14'h3001, 1, N, 8'h00);
      step();
      trig_in = 1'b0;
      wait_idle("rnd");
      rnd = 1'b0;
      fif.fifo0_waitrequest = 1'b0;
      fif.fifo1_waitrequest = 1'b0;
      check("rnd_drop", 32'(drop_count), 32'd5);
      // trigger while disabled produces nothing
      write_en = 1'b0;
      trig_in = 1'b1;
      step(3);
      trig_in = 1'b0;
      step(30);
      check("dis_evt", 32'(evt_count), 32'd4);
      check("dis_busy", 32'(busy), 32'd0);
      // enable dropped mid-CAPTURE: event still finishes with trailers
      write_en = 1'b1;
      step(2);
      bs1_data = 14'h0010;
      bs2_data = 14'h0020;
      trig_in = 1'b1;
      exp_event(16'd4, 14'h0011, 14'h0021, 1, N, 8'h00);
      step(6);
      write_en = 1'b0;
      trig_in = 1'b0;
      wait_idle("wen");
      check("wen_evt", 32'(evt_count), 32'd5);
      write_en = 1'b1;
      step(2);
      // reset mid-CAPTURE abandons the event and clears counters
      bs1_data = 14'h0100;
      bs2_data = 14'h0200;
      trig_in = 1'b1;
      exp_event(16'd5, 14'h0101, 14'h0201, 1, N, 8'h00);
      step(8);
      reset_reset = 1'b1;
      #1;
      check("mid_rst_write0", 32'(fif.fifo0_write), 32'd0);
      check("mid_rst_write1", 32'(fif.fifo1_write), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_evt", 32'(evt_count), 32'd0);
      check("mid_rst_drop", 32'(drop_count), 32'd0);
      q0.delete();
      q1.delete();
      trig_in = 1'b0;
      step(2);
      reset_reset = 1'b0;
      step(3);
      bs1_data = 14'h2000;
      bs2_data = 14'h0300;
      trig_in = 1'b1;
      exp_event(16'd0, 14'h2001, 14'h0301, 1, N, 8'h00);
      step(2);
      trig_in = 1'b0;
      wait_idle("post_rst");
      check("post_rst_evt", 32'(evt_count), 32'd1);
      check("post_rst_drop", 32'(drop_count), 32'd0);
      step(5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/adc_evt_readout_ctrl.md
Name: adc_evt_readout_ctrl

Overview:
Trigger-driven readout sequencer for the two 14-bit ADC channels (bs1, bs2) feeding the two streaming write FIFOs (fifo_0 for bs1, fifo_1 for bs2). On a trigger it emits one framed event per channel: a header word, NWORDS packed data words, and a trailer word. Each channel has a small skid buffer that absorbs FIFO backpressure. The block sits between the ADC sample inputs and the fifo_N_in Avalon-ST-style write ports. Gating comes from write_en and trigger-mode configuration.

Parameters:
ADC_W, 14, ADC sample width
NWORDS, 64, data words per channel per event (2 samples/word); legal range 1..4095
BUF_DEPTH, 4, per-channel word buffer depth (power of 2, >=2)
HOLDOFF, 16, idle cycles enforced after trailer before next trigger accepted

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  asynchronous active-high reset
bs1_data  in  14  ADC channel 1 sample, valid every clock
bs2_data  in  14  ADC channel 2 sample, valid every clock
trig_in  in  1  external trigger level, synchronous to clk_clk
write_en  in  1  run enable; triggers ignored while low
trig_mode  in  2  0=external, 1=bs1 threshold, 2=bs1 OR bs2 threshold, 3=external OR any threshold
threshold  in  14  unsigned crossing threshold
fifo0_writedata  out  32  channel-1 word to FIFO 0
fifo0_write  out  1  FIFO 0 write request
fifo0_waitrequest  in  1  FIFO 0 stall
fifo1_writedata  out  32  channel-2 word to FIFO 1
fifo1_write  out  1  FIFO 1 write request
fifo1_waitrequest  in  1  FIFO 1 stall
busy  out  1  high in any state other than IDLE
evt_count  out  16  events started, wraps
drop_count  out  16  total dropped data words (both channels), saturates at 0xFFFF

Behaviour:
- Reset (async): FSM=IDLE; buffers flushed; fifoN_write=0, fifoN_writedata=0, busy=0, evt_count=0, drop_count=0, sample/trigger registers=0. Reset mid-event abandons the event with no trailer.
- Input stage: bs1/bs2/trig_in are registered (1 cycle); all detection and capture use the registered values.
- Trigger condition, per cycle, using the registered values:
  - Ext = trig_in rising edge.
  - Threshold on channel x = prev < threshold AND cur >= threshold.
- Trigger acceptance: only in IDLE, with write_en=1 and both buffers empty. Triggers in any other state are ignored and not queued.
- FSM: IDLE -> HEADER -> CAPTURE -> TRAILER -> HOLDOFF -> IDLE.
  - IDLE: accepted trigger on cycle T -> HEADER.
  - HEADER (T+1):
    - Push header to both buffers. Pushes always fit, since both buffers were empty at acceptance.
    - evt_count increments this cycle; the header carries the pre-increment value.
  - CAPTURE:
    - Starts T+1. Samples at T+1..T+2*NWORDS are paired: even sample -> [29:16], odd sample -> [13:0], [31:30] and [15:14] = 0.
    - A word is pushed on each odd-sample cycle.
    - If a channel's buffer is full at push, that word is dropped. drop_count += 1 per channel dropped (saturating). That channel's 8-bit per-event drop counter increments (saturating at 0xFF).
    - After the last word push -> TRAILER.
  - TRAILER: push trailer into each buffer as soon as it is not full (may take several cycles per channel). Once both are pushed -> HOLDOFF.
  - HOLDOFF: count HOLDOFF cycles -> IDLE.
- write_en falling mid-event: the event completes normally.
- Word formats:
  - Header = {4'hA, 3'b0, ch, 8'h00, evt[15:0]}, with ch=0 for bs1 and 1 for bs2.
  - Trailer = {4'hE, 3'b0, ch, drops8, evt[15:0]}.
- FIFO handshake, per channel, independent:
  - fifoN_write = buffer not empty.
  - fifoN_writedata = buffer head, registered, and stable while write&&waitrequest.
  - Pop on write && !waitrequest.
  - Push and pop in the same cycle are both honoured; a full buffer with a simultaneous pop accepts the push (no drop).
- Zero-latency buffer bypass is not required. A word pushed on cycle C first appears on fifoN_write at C+1.

Test Plan:
- trig_mode=0, NWORDS=4, no backpressure, ramp bs1=0,1,2..., trig_in rise -> fifo0 gets A000_0000, 0000_0001 (e.g. samples k,k+1 packed), 4 data words, E000_0000. fifo1 gets A100_0000 ... E100_0000. evt_count=1.
- trig_mode=1, threshold=0x100, bs1 steps 0x0FF->0x100 -> exactly one event. Holding bs1 at 0x100 causes no retrigger. Triggers during CAPTURE and HOLDOFF are ignored.
- fifo0_waitrequest held high for 20 cycles during CAPTURE, NWORDS=8, BUF_DEPTH=4 -> header + first 3 data words retained, 5 words dropped. The fifo0 trailer carries drops8=0x05. fifo1 is unaffected. drop_count=5.
- waitrequest toggled pseudo-randomly -> writedata never changes while write&&waitrequest. Per-channel word order is preserved.
- write_en=0 with trigger -> no output, evt_count unchanged. Dropping write_en mid-CAPTURE -> event still completes with its trailer.
- Assert reset_reset mid-CAPTURE -> fifoN_write=0 immediately. Counters clear. The next trigger produces a clean event with evt=0.
